// File: rtl/mem_req_ctrl_pkg.sv
// Shared types, FSM state encodings and sizing helper for mem_req_ctrl.
package mem_req_ctrl_pkg;

   typedef logic [7:0] tag_t;

   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_DRAIN  = 1'b1;

   // Width needed to count 0..max_out inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return unsigned'($clog2(max_out + 1));
   endfunction

endpackage

// File: rtl/mem_req_ctrl_counter.sv
// Up/down/load counter that never wraps past 0 or past MAX.
module updown_sat_counter
   import mem_req_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned MAX   = 3
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             up,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

   // Load wins; simultaneous up and down cancel out.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (up && !down && count != MAX_C) begin
         count <= count + 1'b1;
      end else if (down && !up && count != '0) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller: limits outstanding requests and discards responses after a flush.
// Optional statistics counters are built when MEM_REQ_CTRL_STATS_EN is defined.
module mem_req_ctrl
   import mem_req_ctrl_pkg::*;
#(
   parameter int unsigned MAX_OUT = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter type         TAG_T   = tag_t
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  TAG_T              req_tag_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   input  logic              mem_rsp_valid_i,
   output logic              rsp_valid_o,
   output logic              fifo_push_o,
   output logic              fifo_pop_o,
   output logic              fifo_flush_o,
   output TAG_T              fifo_data_o,
   output logic [31:0]       stat_issued_o,
   output logic [31:0]       stat_discarded_o
);

   localparam int unsigned   CW        = cnt_width(MAX_OUT);
   localparam logic [CW-1:0] OUT_LIMIT = CW'(MAX_OUT);

   logic [CW-1:0] out_cnt;
   logic [CW-1:0] disc_cnt;
   logic [CW-1:0] disc_load_val;
   logic [0:0]    state;
   logic          can_issue;
   logic          issue;
   logic          rsp_ok;
   logic          rsp_fwd;
   logic          rsp_drop;

   assign state = (disc_cnt != '0) ? ST_DRAIN : ST_NORMAL;

   // rst_n_i gating keeps every handshake output low while reset is held.
   assign can_issue       = rst_n_i && !flush_i && (out_cnt < OUT_LIMIT);
   assign mem_req_valid_o = can_issue && req_valid_i;
   assign req_ready_o     = can_issue && mem_req_ready_i;
   assign issue           = mem_req_valid_o && mem_req_ready_i;

   assign mem_req_addr_o = req_addr_i;
   assign fifo_data_o    = req_tag_i;
   assign fifo_push_o    = issue;
   assign fifo_flush_o   = flush_i;

   // A response with nothing outstanding is ignored so the counters cannot wrap.
   assign rsp_ok   = rst_n_i && mem_rsp_valid_i && (out_cnt != '0);
   assign rsp_fwd  = rsp_ok && !flush_i && (state == ST_NORMAL);
   assign rsp_drop = rsp_ok && !flush_i && (state == ST_DRAIN);

   assign rsp_valid_o = rsp_fwd;
   assign fifo_pop_o  = rsp_fwd;

   assign disc_load_val = out_cnt - CW'(rsp_ok);

   updown_sat_counter #(
      .WIDTH (CW),
      .MAX   (MAX_OUT)
   ) u_out_cnt (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .up       (issue),
      .down     (rsp_ok),
      .load     (1'b0),
      .load_val ('0),
      .count    (out_cnt)
   );

   updown_sat_counter #(
      .WIDTH (CW),
      .MAX   (MAX_OUT)
   ) u_disc_cnt (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .up       (1'b0),
      .down     (rsp_drop),
      .load     (flush_i),
      .load_val (disc_load_val),
      .count    (disc_cnt)
   );

`ifdef MEM_REQ_CTRL_STATS_EN
   logic [31:0] issued_q;
   logic [31:0] discarded_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         issued_q    <= '0;
         discarded_q <= '0;
      end else begin
         if (issue) begin
            issued_q <= issued_q + 32'd1;
         end
         if (rsp_drop) begin
            discarded_q <= discarded_q + 32'd1;
         end
      end
   end

   assign stat_issued_o    = issued_q;
   assign stat_discarded_o = discarded_q;
`else
   assign stat_issued_o    = '0;
   assign stat_discarded_o = '0;
`endif

`ifndef SYNTHESIS
   rsp_without_outstanding: assert property (
      @(posedge clk_i) disable iff (!rst_n_i) !(mem_rsp_valid_i && out_cnt == '0));

   disc_within_outstanding: assert property (
      @(posedge clk_i) disable iff (!rst_n_i) disc_cnt <= out_cnt);
`endif

endmodule
